load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle load/store unit directly downstream of the ALU. It takes the ALU-computed effective address (rs1+imm), the rs2 store data and funct3, and turns them into one word-aligned memory bus transaction.
- For loads it extracts the addressed byte/halfword/word, zero- or sign-extends it, and returns it for writeback.
- It detects misaligned and illegal accesses and reports them without touching memory.

Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit in cycles. Only used when LSU_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request from the execute stage
- req_ready  out  1  unit idle, can accept a request
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  rs2 value (store data)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  word address, bits[1:0]=0
- mem_wdata  out  32  store data replicated into the addressed lanes
- mem_wstrb  out  4  byte write strobes; 0000 for loads
- mem_rdata  in  32  load data, valid when mem_ready=1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_misaligned  out  1  address misaligned for the access size
- rsp_err  out  1  illegal funct3, or bus timeout

Behaviour:
- Reset (synchronous): state=IDLE. Every output register cleared: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_data=0, rsp_misaligned=0, rsp_err=0. req_ready=1 after reset.
  - Reset during MEM drops mem_valid at that edge; the bus owner must tolerate an abandoned request.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1. Handshake is req_valid & req_ready; on it, all req_* inputs are latched.
  - Illegal funct3 → RESP with rsp_err=1. Illegal means: loads 011/110/111; stores with funct3[2]=1 or 011.
  - Misaligned → RESP with rsp_misaligned=1. Misaligned means: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Otherwise → MEM, with mem_valid=1 from the next cycle.
  - Illegal takes priority over misaligned.
- MEM:
  - req_ready=0. mem_valid, mem_addr, mem_wdata and mem_wstrb stay constant until mem_ready.
  - On mem_ready=1, load data is captured and the unit goes → RESP.
  - mem_ready while mem_valid=0 is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE. rsp_* hold their values until the next RESP.
- Latency: accept at cycle 0, mem_valid at cycle 1. If mem_ready arrives in cycle 1, rsp_valid is at cycle 2. An error response is at cycle 1.
- Store lanes (off = addr[1:0]):
  - SB: wstrb=0001<<off, wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<off, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata=wdata.
- Load extraction: the byte or halfword at offset off within mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Little-endian byte order.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to MEM and increments on each MEM cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES, mem_valid is dropped and the unit goes → RESP with rsp_err=1 and rsp_data=0.
  - mem_ready arriving on the same cycle as the limit wins: normal completion.
- LSU_TIMEOUT_EN undefined: no counter; the unit waits in MEM indefinitely.

Decomposition:
- Shared package/defines header holds:
  - funct3 encodings: LSU_F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encodings.
  - LSU_TIMEOUT_W=16.
- One natural sub-module: lsu_load_align. It is combinational: rdata, offset and funct3 in; extended 32-bit result out. It is reused by a future AMO path.

Test Plan:
- LW at 0x0000_1004, mem_rdata=0xDEADBEEF, mem_ready in the first MEM cycle → mem_addr=0x1004, wstrb=0000, rsp_valid at cycle 2, rsp_data=0xDEADBEEF.
- LB at 0x1003 with rdata=0x80FF_0000 → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x1002 → 0x000080FF.
- SB at 0x2001 with wdata=0x123456AB → mem_addr=0x2000, wstrb=0010, mem_wdata=0xABABABAB. SH at 0x2002 → wstrb=1100, mem_wdata=0x56AB56AB.
- LH at 0x3001 and SW at 0x3002 → no mem_valid, rsp_valid at cycle 1, rsp_misaligned=1. Load funct3=011 → rsp_err=1, rsp_misaligned=0.
- mem_ready held low for 5 cycles → mem_* stable and req_ready=0 throughout; rst asserted in wait cycle 3 → mem_valid=0 and req_ready=1 on the next edge, no rsp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted → rsp_err=1 after 4 MEM cycles. Repeat with mem_ready on cycle 4 → normal completion.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encodings, timeout counter width and access-classification helpers.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_F3_LB  = 3'b000;
  localparam logic [2:0] LSU_F3_LH  = 3'b001;
  localparam logic [2:0] LSU_F3_LW  = 3'b010;
  localparam logic [2:0] LSU_F3_LBU = 3'b100;
  localparam logic [2:0] LSU_F3_LHU = 3'b101;
  localparam logic [2:0] LSU_F3_SB  = 3'b000;
  localparam logic [2:0] LSU_F3_SH  = 3'b001;
  localparam logic [2:0] LSU_F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned LSU_TIMEOUT_W = 16;

  // Loads: 011/110/111 are illegal. Stores: anything with bit 2 set or 011.
  function automatic logic lsu_f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3[2] || (f3[1:0] == 2'b11);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the byte/halfword/word at the given
// little-endian offset inside the bus word and zero- or sign-extends it.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LSU_F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_F3_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_F3_LW:  data = shifted;
      LSU_F3_LBU: data = {24'h0, shifted[7:0]};
      LSU_F3_LHU: data = {16'h0, shifted[15:0]};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns an effective address, store data and
// funct3 into one word-aligned bus transaction and returns extended load data.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        rsp_err
);

  logic [1:0]  state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic        req_illegal;
  logic        req_misaligned;

`ifdef LSU_TIMEOUT_EN
  localparam logic [LSU_TIMEOUT_W-1:0] TIMEOUT_LAST = LSU_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [LSU_TIMEOUT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  assign req_ready      = (state == ST_IDLE);
  assign req_illegal    = lsu_f3_illegal(req_store, req_funct3);
  assign req_misaligned = lsu_misaligned(req_funct3, req_addr[1:0]);

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Replicate store data into every lane and enable only the addressed ones.
  always_comb begin
    lane_strb  = '0;
    lane_wdata = '0;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          lane_strb  = 4'b0001 << req_addr[1:0];
          lane_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          lane_strb  = 4'b0011 << req_addr[1:0];
          lane_wdata = {2{req_wdata[15:0]}};
        end
        2'b10: begin
          lane_strb  = 4'b1111;
          lane_wdata = req_wdata;
        end
        default: begin
          lane_strb  = '0;
          lane_wdata = '0;
        end
      endcase
    end
  end

  // Request/bus/response sequencing; rsp_* are only written on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      store_q        <= 1'b0;
      funct3_q       <= '0;
      off_q          <= '0;
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
      rsp_err        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (req_illegal) begin
              state          <= ST_RESP;
              rsp_valid      <= 1'b1;
              rsp_data       <= '0;
              rsp_misaligned <= 1'b0;
              rsp_err        <= 1'b1;
            end else if (req_misaligned) begin
              state          <= ST_RESP;
              rsp_valid      <= 1'b1;
              rsp_data       <= '0;
              rsp_misaligned <= 1'b1;
              rsp_err        <= 1'b0;
            end else begin
              state     <= ST_MEM;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= lane_wdata;
              mem_wstrb <= lane_strb;
`ifdef LSU_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            state          <= ST_RESP;
            mem_valid      <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_data       <= store_q ? 32'h0 : load_data;
            rsp_misaligned <= 1'b0;
            rsp_err        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state          <= ST_RESP;
            mem_valid      <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_data       <= '0;
            rsp_misaligned <= 1'b0;
            rsp_err        <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
